// File: rtl/macro_decoder_bin_pipe_pkg.sv
// rtl/macro_decoder_bin_pipe_pkg.sv - occupancy encoding for the decoder output stage
package macro_decoder_bin_pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/macro_decoder_bin_lane.sv
// rtl/macro_decoder_bin_lane.sv - combinational single-channel one-hot/thermometer decode
`include "macro_decoder_defs.vh"

module macro_decoder_bin_lane
    import macro_decoder_bin_pipe_pkg::*;
#(
    parameter int INPUT_WIDTH  = 3,
    parameter int OUTPUT_WIDTH = 1 << INPUT_WIDTH
) (
    input  logic [INPUT_WIDTH-1:0]  d_i,
    input  logic                    en_i,
    input  logic                    mode_i,
    output logic [OUTPUT_WIDTH-1:0] q_o,
    output logic                    oor_o
);

    // Widened compare so OUTPUT_WIDTH == 2^INPUT_WIDTH never overflows.
    logic [31:0] d_wide;
    assign d_wide = 32'(d_i);

    always_comb begin
        q_o   = '0;
        oor_o = 1'b0;
        if (en_i) begin
            if (d_wide >= 32'(OUTPUT_WIDTH)) begin
                oor_o = 1'b1;
            end else begin
                for (int i = 0; i < OUTPUT_WIDTH; i++) begin
                    if (mode_i == `DEC_MODE_THERM) q_o[i] = (32'(i) <= d_wide);
                    else                           q_o[i] = (32'(i) == d_wide);
                end
            end
        end
    end

endmodule

// File: rtl/macro_decoder_defs.vh
// rtl/macro_decoder_defs.vh - shared decode mode encodings
`ifndef MACRO_DECODER_DEFS_VH
`define MACRO_DECODER_DEFS_VH

`define DEC_MODE_ONEHOT 1'b0
`define DEC_MODE_THERM  1'b1

`endif

// File: rtl/macro_decoder_bin_pipe.sv
// rtl/macro_decoder_bin_pipe.sv - multi-channel registered binary decoder with 2-entry skid stage
module macro_decoder_bin_pipe
    import macro_decoder_bin_pipe_pkg::*;
#(
    parameter int INPUT_WIDTH  = 3,
    parameter int OUTPUT_WIDTH = 1 << INPUT_WIDTH,
    parameter int CHANNELS     = 2
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             flush,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [CHANNELS*INPUT_WIDTH-1:0]  s_d,
    input  logic [CHANNELS-1:0]              s_en,
    input  logic                             s_mode,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [CHANNELS*OUTPUT_WIDTH-1:0] m_q,
    output logic [CHANNELS-1:0]              m_oor
);

    localparam int PW = CHANNELS*OUTPUT_WIDTH + CHANNELS;

    logic [CHANNELS*OUTPUT_WIDTH-1:0] dec_q;
    logic [CHANNELS-1:0]              dec_oor;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        macro_decoder_bin_lane #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .OUTPUT_WIDTH(OUTPUT_WIDTH)
        ) u_lane (
            .d_i   (s_d[c*INPUT_WIDTH +: INPUT_WIDTH]),
            .en_i  (s_en[c]),
            .mode_i(s_mode),
            .q_o   (dec_q[c*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
            .oor_o (dec_oor[c])
        );
    end

    occ_e          occ_q, occ_d;
    logic [PW-1:0] main_q, main_d, skid_q, skid_d;
    logic          s_ready_q;
    logic          accept, drain;

    assign accept = s_valid & s_ready_q;
    assign drain  = (occ_q != OCC_EMPTY) & m_ready;

    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    main_d = {dec_q, dec_oor};
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && drain) begin
                    main_d = {dec_q, dec_oor};
                end else if (accept) begin
                    skid_d = {dec_q, dec_oor};
                    occ_d  = OCC_TWO;
                end else if (drain) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (drain) begin
                    main_d = skid_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        // Flush drops everything buffered, including a same-cycle accept.
        if (flush) begin
            occ_d  = OCC_EMPTY;
            main_d = '0;
            skid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            occ_q     <= OCC_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b1;
        end else begin
            occ_q     <= occ_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= (occ_d != OCC_TWO);
        end
    end

    assign s_ready        = s_ready_q;
    assign m_valid        = (occ_q != OCC_EMPTY);
    assign {m_q, m_oor}   = main_q;

endmodule

// File: tb/tb_macro_decoder_bin_pipe.sv
// tb/tb_macro_decoder_bin_pipe.sv - self-checking bench for macro_decoder_bin_pipe
module tb_macro_decoder_bin_pipe;

    localparam int IW  = 3;
    localparam int OW  = 8;
    localparam int CH  = 2;
    localparam int OW1 = 6;
    localparam int EW  = CH*OW + CH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn, flush;
    logic              s_valid, s_ready, s_mode, m_valid, m_ready;
    logic [CH*IW-1:0]  s_d;
    logic [CH-1:0]     s_en, m_oor;
    logic [CH*OW-1:0]  m_q;

    logic              s1_valid, s1_ready, s1_mode, m1_valid, m1_ready;
    logic [CH*IW-1:0]  s1_d;
    logic [CH-1:0]     s1_en, m1_oor;
    logic [CH*OW1-1:0] m1_q;

    macro_decoder_bin_pipe #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .CHANNELS(CH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_d(s_d), .s_en(s_en), .s_mode(s_mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_q(m_q), .m_oor(m_oor)
    );

    macro_decoder_bin_pipe #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW1), .CHANNELS(CH)) dut_ow6 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .s_valid(s1_valid), .s_ready(s1_ready), .s_d(s1_d), .s_en(s1_en), .s_mode(s1_mode),
        .m_valid(m1_valid), .m_ready(m1_ready), .m_q(m1_q), .m_oor(m1_oor)
    );

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_fifo[$];

    // Expected {q, oor} for one transfer, built from the decode rules with shifts.
    function automatic logic [EW-1:0] model(int ow, logic [CH*IW-1:0] d, logic [CH-1:0] en, logic mode);
        logic [63:0]   q   = '0;
        logic [CH-1:0] oor = '0;
        for (int c = 0; c < CH; c++) begin
            int di = int'(d[c*IW +: IW]);
            if (en[c]) begin
                if (di >= ow) oor[c] = 1'b1;
                else if (mode) q = q | ((((64'd1 << (di + 1)) - 64'd1)) << (c*ow));
                else           q = q | ((64'd1 << di) << (c*ow));
            end
        end
        return {q[CH*OW-1:0], oor};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(logic sv, logic [CH*IW-1:0] d, logic [CH-1:0] en, logic md,
                         logic mr, logic fl, logic rn);
        logic acc, drn;
        chk("m_valid", 32'(m_valid), 32'(exp_fifo.size() != 0));
        chk("s_ready", 32'(s_ready), 32'(exp_fifo.size() < 2));
        if (exp_fifo.size() != 0) begin
            chk("m_q",   32'(m_q),   32'(exp_fifo[0][EW-1:CH]));
            chk("m_oor", 32'(m_oor), 32'(exp_fifo[0][CH-1:0]));
        end
        s_valid = sv; s_d = d; s_en = en; s_mode = md;
        m_ready = mr; flush = fl; resetn = rn;
        acc = sv && (exp_fifo.size() < 2);
        drn = mr && (exp_fifo.size() != 0);
        @(posedge clk);
        if (!rn || fl) begin
            exp_fifo.delete();
        end else begin
            if (drn) void'(exp_fifo.pop_front());
            if (acc) exp_fifo.push_back(model(OW, d, en, md));
        end
        @(negedge clk);
    endtask

    initial begin
        logic [EW-1:0] e1;
        resetn = 1'b0; flush = 1'b0;
        s_valid = 1'b0; s_d = '0; s_en = '0; s_mode = 1'b0; m_ready = 1'b0;
        s1_valid = 1'b0; s1_d = '0; s1_en = '0; s1_mode = 1'b0; m1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
            chk("idle_m_q", 32'(m_q), 32'h0);
        end

        // One-hot, both channels
        cycle(1'b1, {3'd5, 3'd2}, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("onehot_q",   32'(m_q),   32'h2004);
        chk("onehot_oor", 32'(m_oor), 32'h0);

        // Thermometer with partial enables
        cycle(1'b1, {3'd0, 3'd7}, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("therm_a", 32'(m_q), 32'h00FF);
        cycle(1'b1, {3'd3, 3'd6}, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("therm_b", 32'(m_q), 32'h0F00);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Narrow output width: out-of-range indices
        s1_valid = 1'b1; s1_d = {3'd6, 3'd5}; s1_en = 2'b11; s1_mode = 1'b0;
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ow6_valid", 32'(m1_valid), 32'h1);
        chk("ow6_q",     32'(m1_q),     32'h020);
        chk("ow6_oor",   32'(m1_oor),   32'h2);
        s1_d = {3'd7, 3'd4}; s1_mode = 1'b1;
        e1 = model(OW1, {3'd7, 3'd4}, 2'b11, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ow6_therm_q",   32'(m1_q),   32'(e1[EW-1:CH]));
        chk("ow6_therm_oor", 32'(m1_oor), 32'(e1[CH-1:0]));
        s1_valid = 1'b0;

        // Backpressure: three offers, two accepted, then ordered drain
        cycle(1'b1, {3'd1, 3'd0}, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, {3'd2, 3'd3}, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_s_ready", 32'(s_ready), 32'h0);
        cycle(1'b1, {3'd4, 3'd4}, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("bp_second_valid", 32'(m_valid), 32'h1);
        chk("bp_second_q",     32'(m_q),     32'h0408);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Flush with two entries buffered
        cycle(1'b1, {3'd6, 3'd1}, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, {3'd7, 3'd2}, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("flush_m_valid", 32'(m_valid), 32'h0);
        chk("flush_s_ready", 32'(s_ready), 32'h1);

        // Reset mid-stream with two entries buffered
        cycle(1'b1, {3'd3, 3'd5}, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, {3'd4, 3'd6}, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, {3'd1, 3'd1}, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h1);
        chk("rst_m_q",     32'(m_q),     32'h0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 6'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0), 1'b1);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
